// File: rtl/sram_bridge_pkg.sv
// sram_bridge_pkg: shared FSM states and transfer size codes for the SRAM-like bridge
package sram_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        DONE,
        DRAIN
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/sraml_wen_enc.sv
// sraml_wen_enc: maps byte enables to a transfer size and the byte offset of the lowest enabled byte
module sraml_wen_enc
    import sram_bridge_pkg::*;
#(
    parameter int WEN_W = 4,
    parameter int OFF_W = $clog2(WEN_W)
) (
    input  logic [WEN_W-1:0] wen,
    output logic [1:0]       size,
    output logic [OFF_W-1:0] off
);

    localparam int CNT_W = $clog2(WEN_W + 1);

    logic [CNT_W-1:0] cnt;
    logic [OFF_W-1:0] low;
    logic             pair;

    // Count enabled bytes and find the lowest one; only single bytes and adjacent pairs get a narrow size
    always_comb begin
        cnt = '0;
        low = '0;
        for (int i = WEN_W - 1; i >= 0; i--) begin
            cnt = cnt + CNT_W'(wen[i]);
            if (wen[i]) low = OFF_W'(i);
        end
        pair = (wen >> low) == WEN_W'(3);
        size = (cnt == CNT_W'(1)) ? SZ_B : ((cnt == CNT_W'(2)) && pair) ? SZ_H : SZ_W;
        off  = (size == SZ_W) ? '0 : low;
    end

endmodule

// File: rtl/sram2sraml_bridge.sv
// sram2sraml_bridge: mem-stage SRAM port to SRAM-like bus bridge with latched request, flush drain and held load data
module sram2sraml_bridge
    import sram_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WEN_W  = DATA_W / 8,
    parameter int OFF_W  = $clog2(WEN_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sram_en,
    input  logic [ADDR_W-1:0] sram_addr,
    input  logic [WEN_W-1:0]  sram_wen,
    input  logic [DATA_W-1:0] sram_wdata,
    input  logic [1:0]        sram_rsize,
    output logic [DATA_W-1:0] sram_rdata,
    output logic              stall,
    input  logic              pipe_hold,
    input  logic              flush,
    output logic              req,
    output logic              wr,
    output logic [1:0]        size,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              addr_ok,
    input  logic              data_ok
);

    state_t            state, state_n;
    logic              lat_wr;
    logic [1:0]        lat_size;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              flush_flag;
    logic              flush_seen;
    logic              rd_take;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        enc_size;
    logic [OFF_W-1:0]  enc_off;
    logic              in_wr;
    logic [1:0]        in_size;
    logic [ADDR_W-1:0] in_addr;

    sraml_wen_enc #(
        .WEN_W(WEN_W),
        .OFF_W(OFF_W)
    ) u_enc (
        .wen (sram_wen),
        .size(enc_size),
        .off (enc_off)
    );

    assign in_wr      = |sram_wen;
    assign in_size    = in_wr ? enc_size : sram_rsize;
    assign in_addr    = in_wr ? {sram_addr[ADDR_W-1:OFF_W], enc_off} : sram_addr;
    assign flush_seen = flush_flag | flush;
    assign stall      = sram_en & (state != DONE);
    assign sram_rdata = rdata_q;

    // Next state, bus request fields and the decision whether this cycle's read data is kept
    always_comb begin
        state_n = state;
        req     = 1'b0;
        wr      = lat_wr;
        size    = lat_size;
        addr    = lat_addr;
        wdata   = lat_wdata;
        rd_take = 1'b0;
        case (state)
            IDLE: begin
                req   = sram_en & ~flush;
                wr    = in_wr;
                size  = in_size;
                addr  = in_addr;
                wdata = sram_wdata;
                if (req) state_n = !addr_ok ? ADDR : data_ok ? DONE : DATA;
                rd_take = req & addr_ok & data_ok & ~in_wr;
            end
            ADDR: begin
                req = 1'b1;
                if (addr_ok) state_n = data_ok ? (flush_seen ? IDLE : DONE) : (flush_seen ? DRAIN : DATA);
                rd_take = addr_ok & data_ok & ~flush_seen & ~lat_wr;
            end
            DATA: begin
                if (data_ok) state_n = flush ? IDLE : DONE;
                else if (flush) state_n = DRAIN;
                rd_take = data_ok & ~flush & ~lat_wr;
            end
            DONE:    state_n = (~pipe_hold | flush) ? IDLE : DONE;
            DRAIN:   state_n = data_ok ? IDLE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    // State, request-field latch, flush-during-address flag and held load data
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_wr     <= 1'b0;
            lat_size   <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            flush_flag <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state      <= state_n;
            flush_flag <= (state == ADDR) & flush_seen;
            if (state == IDLE && req) begin
                lat_wr    <= wr;
                lat_size  <= size;
                lat_addr  <= addr;
                lat_wdata <= wdata;
            end
            if (rd_take) rdata_q <= rdata;
        end
    end

endmodule

// File: tb/tb_sram2sraml_bridge.sv
// tb_sram2sraml_bridge: directed and randomized checks of the bridge against a transaction-level model
module tb_sram2sraml_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        sram_en;
    logic [31:0] sram_addr;
    logic [3:0]  sram_wen;
    logic [31:0] sram_wdata;
    logic [1:0]  sram_rsize;
    logic [31:0] sram_rdata;
    logic        stall;
    logic        pipe_hold;
    logic        flush;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    int          passed = 0;
    int          total  = 0;
    logic [31:0] exp_rdata = 32'h0;

    always #5 clk = ~clk;

    sram2sraml_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .sram_en   (sram_en),
        .sram_addr (sram_addr),
        .sram_wen  (sram_wen),
        .sram_wdata(sram_wdata),
        .sram_rsize(sram_rsize),
        .sram_rdata(sram_rdata),
        .stall     (stall),
        .pipe_hold (pipe_hold),
        .flush     (flush),
        .req       (req),
        .wr        (wr),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .addr_ok   (addr_ok),
        .data_ok   (data_ok)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Bus view of a store: one byte -> byte at its own offset, an adjacent pair -> half at the lower byte, anything else -> aligned word
    function automatic void model(input logic [3:0] wen, input logic [31:0] a, input logic [1:0] rs,
                                  output logic [1:0] sz, output logic [31:0] ea);
        int low = 0;
        for (int i = 3; i >= 0; i--) if (wen[i]) low = i;
        if (wen == 4'b0000) begin
            sz = rs;
            ea = a;
        end else if (wen inside {4'b0001, 4'b0010, 4'b0100, 4'b1000}) begin
            sz = 2'd0;
            ea = (a & ~32'd3) + 32'(low);
        end else if (wen inside {4'b0011, 4'b0110, 4'b1100}) begin
            sz = 2'd1;
            ea = (a & ~32'd3) + 32'(low);
        end else begin
            sz = 2'd2;
            ea = a & ~32'd3;
        end
    endfunction

    // One complete transfer: addr_ok after al cycles, data_ok dl cycles after that, then DONE and release
    task automatic txn(input string tag, input logic [3:0] wen, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] rs, input int al, input int dl, input logic [31:0] rd);
        logic [1:0]  esz;
        logic [31:0] ea;
        model(wen, a, rs, esz, ea);
        sram_en    = 1'b1;
        sram_wen   = wen;
        sram_addr  = a;
        sram_wdata = wd;
        sram_rsize = rs;
        for (int c = 0; c <= al + dl; c++) begin
            if (c > 0) begin
                sram_addr  = $urandom;
                sram_wdata = $urandom;
                sram_wen   = 4'($urandom);
                sram_rsize = 2'($urandom);
            end
            addr_ok = (c == al);
            data_ok = (c == al + dl);
            rdata   = data_ok ? rd : $urandom;
            #1;
            chk({tag, ".stall"}, stall, 1'b1);
            if (c <= al) begin
                chk({tag, ".req"}, req, 1'b1);
                chk({tag, ".wr"}, wr, wen != 4'b0);
                chk({tag, ".size"}, size, esz);
                chk({tag, ".addr"}, addr, ea);
                if (wen != 4'b0) chk({tag, ".wdata"}, wdata, wd);
            end else begin
                chk({tag, ".req_low"}, req, 1'b0);
            end
            tick();
        end
        addr_ok = 1'b0;
        data_ok = 1'b0;
        if (wen == 4'b0) exp_rdata = rd;
        #1;
        chk({tag, ".done_stall"}, stall, 1'b0);
        chk({tag, ".done_req"}, req, 1'b0);
        chk({tag, ".rdata"}, sram_rdata, exp_rdata);
        sram_en = 1'b0;
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        sram_en    = 1'b0;
        sram_addr  = 32'h0;
        sram_wen   = 4'h0;
        sram_wdata = 32'h0;
        sram_rsize = 2'd2;
        pipe_hold  = 1'b0;
        flush      = 1'b0;
        rdata      = 32'h0;
        addr_ok    = 1'b0;
        data_ok    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset.req", req, 1'b0);
        chk("reset.stall", stall, 1'b0);
        chk("reset.rdata", sram_rdata, 32'h0);
        tick();

        txn("rd_basic", 4'b0000, 32'h100, 32'h0, 2'd2, 2, 2, 32'hDEADBEEF);
        txn("wr_byte", 4'b0100, 32'h203, 32'hA5A5A5A5, 2'd0, 1, 1, 32'h11111111);
        txn("wr_half", 4'b1100, 32'h203, 32'h5A5A5A5A, 2'd0, 0, 2, 32'h22222222);
        txn("wr_word", 4'b1111, 32'h203, 32'h0BADF00D, 2'd0, 0, 0, 32'h33333333);
        txn("wr_gap", 4'b0101, 32'h207, 32'h01020304, 2'd0, 1, 0, 32'h44444444);
        txn("wr_three", 4'b0111, 32'h20B, 32'h05060708, 2'd0, 0, 1, 32'h55555555);

        // zero-wait read held in DONE by pipe_hold
        sram_en   = 1'b1;
        sram_wen  = 4'b0;
        sram_addr = 32'h300;
        pipe_hold = 1'b1;
        addr_ok   = 1'b1;
        data_ok   = 1'b1;
        rdata     = 32'hCAFE0001;
        tick();
        exp_rdata = 32'hCAFE0001;
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rdata = $urandom;
            #1;
            chk("hold.stall", stall, 1'b0);
            chk("hold.req", req, 1'b0);
            chk("hold.rdata", sram_rdata, exp_rdata);
            tick();
        end
        pipe_hold = 1'b0;
        sram_en   = 1'b0;
        tick();
        sram_en = 1'b1;
        #1;
        chk("hold.idle_req", req, 1'b1);
        chk("hold.idle_stall", stall, 1'b1);
        sram_en = 1'b0;
        tick();

        // flush during ADDR: request kept until addr_ok, then the data is drained away
        sram_en   = 1'b1;
        sram_addr = 32'h400;
        #1;
        chk("fa.req0", req, 1'b1);
        tick();
        flush = 1'b1;
        #1;
        chk("fa.req1", req, 1'b1);
        chk("fa.addr1", addr, 32'h400);
        tick();
        flush   = 1'b0;
        addr_ok = 1'b1;
        #1;
        chk("fa.req2", req, 1'b1);
        tick();
        addr_ok = 1'b0;
        #1;
        chk("fa.drain_req", req, 1'b0);
        chk("fa.drain_stall", stall, 1'b1);
        tick();
        data_ok = 1'b1;
        rdata   = 32'h12345678;
        #1;
        chk("fa.drain_stall2", stall, 1'b1);
        tick();
        data_ok = 1'b0;
        #1;
        chk("fa.idle_req", req, 1'b1);
        chk("fa.rdata", sram_rdata, exp_rdata);
        sram_en = 1'b0;
        tick();

        // flush together with data_ok in DATA: straight to IDLE, data dropped
        sram_en   = 1'b1;
        sram_addr = 32'h500;
        addr_ok   = 1'b1;
        tick();
        addr_ok = 1'b0;
        flush   = 1'b1;
        data_ok = 1'b1;
        rdata   = 32'h55AA55AA;
        #1;
        chk("fd.req", req, 1'b0);
        tick();
        flush   = 1'b0;
        data_ok = 1'b0;
        #1;
        chk("fd.idle_req", req, 1'b1);
        chk("fd.stall", stall, 1'b1);
        chk("fd.rdata", sram_rdata, exp_rdata);
        sram_en = 1'b0;
        tick();

        // reset while waiting for data
        sram_en   = 1'b1;
        sram_addr = 32'h600;
        addr_ok   = 1'b1;
        tick();
        addr_ok = 1'b0;
        rst     = 1'b1;
        tick();
        rst     = 1'b0;
        sram_en = 1'b0;
        exp_rdata = 32'h0;
        #1;
        chk("rst.req", req, 1'b0);
        chk("rst.stall", stall, 1'b0);
        chk("rst.rdata", sram_rdata, exp_rdata);
        sram_en = 1'b1;
        #1;
        chk("rst.idle_req", req, 1'b1);
        sram_en = 1'b0;
        tick();

        for (int n = 0; n < 30; n++) begin
            logic [3:0] w;
            w = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            txn("rand", w, $urandom, $urandom, 2'($urandom_range(0, 2)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
